hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
// - Pipeline hazard unit for the OTTER pipeline; replaces value-compare forwarding with register-address matching.
// - Captures the decode-stage rs1/rs2 addresses into its own execute-stage copies.
// - Drives per-operand forward selects for the ALU srcA/srcB muxes from any of NUM_FWD_STAGES downstream stages.
// - Generates load-use stalls and bubbles, plus flushes for taken branches and jumps.
// PARAMETERS
// - REG_AW          5  register address width
// - NUM_FWD_STAGES  2  forward sources (0 = MEM, 1 = WB, 2 = post-WB); legal range 1..3
// - LOAD_LAT        1  stall cycles inserted per load-use hazard; legal range 1..3
// - SELW            $clog2(NUM_FWD_STAGES+1)  local parameter: forward select width
// PORTS
// - CLK               in   1                     clock; all state updates on posedge
// - RST_N             in   1                     reset; synchronous, active-low
// - id_rs1_addr       in   REG_AW                decode rs1 address
// - id_rs2_addr       in   REG_AW                decode rs2 address
// - id_rs1_used       in   1                     decode instruction reads rs1
// - id_rs2_used       in   1                     decode instruction reads rs2
// - ex_rd_addr        in   REG_AW                execute-stage destination
// - ex_regwrite       in   1                     execute-stage register write
// - ex_memread        in   1                     execute-stage instruction is a load
// - ex_branch_taken   in   1                     taken branch or jump resolved in execute
// - fwd_rd_addr       in   NUM_FWD_STAGES*REG_AW destinations; slice k = stage k
// - fwd_regwrite      in   NUM_FWD_STAGES        register write valid per stage
// - fwd_sel_a         out  SELW                  srcA select: 0 = regfile, k+1 = stage k
// - fwd_sel_b         out  SELW                  srcB select; same encoding
// - stall_pc          out  1                     hold PC
// - stall_id          out  1                     hold IF/ID register
// - bubble_ex         out  1                     load NOP into ID/EX
// - flush_id          out  1                     clear IF/ID register
// - flush_ex          out  1                     clear ID/EX register
// - perf_stall_cnt    out  32                    load-use stall cycle count (macro-gated)
// - perf_flush_cnt    out  32                    flush event count (macro-gated)
// BEHAVIOUR
// - Reset (RST_N=0 at posedge):
//   - FSM goes to IDLE; lu_cnt=0.
//   - EX copies ex_rs1/ex_rs2 and ex_rs*_used are cleared to 0.
//   - Counters are cleared to 0.
//   - While RST_N=0, all outputs are gated to 0.
// - EX copies:
//   - Normal cycle: load id_rs* and id_rs*_used at each posedge.
//   - Bubble or flush cycle: clear to 0 instead.
// - Forward select (combinational from EX copies):
//   - A source is a hit when ex_rsN_used=1, ex_rsN!=0, fwd_regwrite[k]=1 and fwd_rd[k]==ex_rsN.
//   - The youngest hit wins (lowest k); sel = k+1.
//   - No hit gives sel=0. x0 is never forwarded.
//   - Lanes A and B are independent; both may select the same stage.
// - Load-use hazard, combinational and qualified in IDLE only:
//   - Condition: ex_memread & ex_regwrite & ex_rd_addr!=0
//   - AND ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
// - FSM states: IDLE, LU_STALL.
//   - IDLE, hazard & !ex_branch_taken:
//     - Assert stall_pc=stall_id=bubble_ex in the same cycle.
//     - If LOAD_LAT>1: lu_cnt<=LOAD_LAT-1 and go to LU_STALL; else remain in IDLE.
//   - LU_STALL:
//     - stall_pc=stall_id=bubble_ex=1.
//     - lu_cnt decrements each cycle; go to IDLE when it reaches 1.
//     - No new hazard is evaluated in this state.
// - Taken branch:
//   - ex_branch_taken=1 gives flush_id=flush_ex=1 in the same cycle.
//   - It overrides any stall: all stall outputs are 0, the FSM goes to IDLE and lu_cnt goes to 0.
// - Priority: reset > flush > load-use stall > normal.
// - Latency: forward selects and stall/flush outputs are 0-cycle (combinational); EX copies are 1 cycle.
// CONFIGURATION
// - HAZARD_PERF_CNT_EN defined:
//   - perf_stall_cnt +1 per cycle with stall_pc=1.
//   - perf_flush_cnt +1 per cycle with flush_ex=1.
//   - Both wrap at 2^32.
// - HAZARD_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops exist.
// STRUCTURE
// - hazard_pkg holds:
//   - hz_state_t enum (IDLE, LU_STALL);
//   - FWD_REGFILE = 0 constant;
//   - function fwd_sel_w(n) returning $clog2(n+1).
// - Sub-module fwd_select_lane (one source address against all stages; priority encoder), instantiated for A and B.
// TESTING
// - x5 written by stage 0 (add) and stage 1, EX rs1=x5 -> fwd_sel_a=1 (youngest wins).
// - EX rs2=x7 matches stage 1 only -> fwd_sel_b=2, fwd_sel_a=0.
// - fwd_rd[0]=x0 with regwrite, EX rs1=x0 -> fwd_sel_a=0.
// - lw x3 in EX, ID add x4,x3,x1, LOAD_LAT=2:
//   - stall_pc=stall_id=bubble_ex=1 for exactly 2 cycles;
//   - the cycle after the first bubble has EX copies = 0.
// - ex_branch_taken during the second LU_STALL cycle:
//   - flush_id=flush_ex=1 and stall_pc=0;
//   - next cycle FSM=IDLE.
// - RST_N=0 mid-stall:
//   - all outputs 0;
//   - with the macro defined, counters read 0 after reset;
//   - with the macro undefined, counters read 0 always.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the OTTER hazard / forwarding unit.
//   hz_state_t   : load-use FSM states
//   FWD_REGFILE  : forward-select code meaning "use register file value"
//   fwd_sel_w(n) : width of a forward select covering n forward stages
package hazard_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  localparam int unsigned FWD_REGFILE = 0;

  function automatic int unsigned fwd_sel_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_select_lane.sv
// One ALU operand lane: matches a source register against every forward stage
// and returns the select of the youngest (lowest index) stage that writes it.
//   i_src_addr     : EX-stage source register address
//   i_src_used     : EX-stage instruction actually reads this source
//   i_fwd_rd_addr  : packed destinations, slice k = stage k
//   i_fwd_regwrite : write-enable per stage
//   o_sel          : 0 = register file, k+1 = stage k
module fwd_select_lane
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned SELW           = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic [REG_AW-1:0]                i_src_addr,
  input  logic                             i_src_used,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] i_fwd_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]        i_fwd_regwrite,
  output logic [SELW-1:0]                  o_sel
);

  // Walk from oldest to youngest so the youngest hit is the last write; x0 never forwards.
  always_comb begin
    o_sel = SELW'(FWD_REGFILE);
    if (i_src_used && (i_src_addr != '0)) begin
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
        if (i_fwd_regwrite[k] && (i_fwd_rd_addr[k*REG_AW +: REG_AW] == i_src_addr)) begin
          o_sel = SELW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit for the OTTER pipeline: address-match forwarding,
// load-use stall/bubble generation and taken-branch flushes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise perf_stall_cnt / perf_flush_cnt are tied to 0.
//   CLK, RST_N                 : clock, synchronous active-low reset
//   id_rs{1,2}_addr/_used      : decode-stage sources
//   ex_rd_addr, ex_regwrite,
//   ex_memread, ex_branch_taken: execute-stage instruction info
//   fwd_rd_addr, fwd_regwrite  : downstream stage destinations (slice k = stage k)
//   fwd_sel_a/b                : ALU srcA/srcB select (0 = regfile, k+1 = stage k)
//   stall_pc, stall_id,
//   bubble_ex                  : load-use stall controls
//   flush_id, flush_ex         : taken-branch flush controls
//   perf_stall_cnt/flush_cnt   : stall-cycle / flush-event counters
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_AW         = 5,
  parameter  int unsigned NUM_FWD_STAGES = 2,
  parameter  int unsigned LOAD_LAT       = 1,
  localparam int unsigned SELW           = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [REG_AW-1:0]                id_rs1_addr,
  input  logic [REG_AW-1:0]                id_rs2_addr,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [REG_AW-1:0]                ex_rd_addr,
  input  logic                             ex_regwrite,
  input  logic                             ex_memread,
  input  logic                             ex_branch_taken,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] fwd_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]        fwd_regwrite,
  output logic [SELW-1:0]                  fwd_sel_a,
  output logic [SELW-1:0]                  fwd_sel_b,
  output logic                             stall_pc,
  output logic                             stall_id,
  output logic                             bubble_ex,
  output logic                             flush_id,
  output logic                             flush_ex,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_flush_cnt
);

  localparam int unsigned LU_CNT_W = 2;

  hz_state_t             r_state, w_next_state;
  logic [LU_CNT_W-1:0]   r_lu_cnt, w_next_lu_cnt;
  logic [REG_AW-1:0]     r_ex_rs1, r_ex_rs2;
  logic                  r_ex_rs1_used, r_ex_rs2_used;
  logic                  w_hazard, w_stall, w_flush;
  logic [SELW-1:0]       w_sel_a, w_sel_b;

  // Load in EX whose destination is read by the instruction in decode.
  assign w_hazard = ex_memread && ex_regwrite && (ex_rd_addr != '0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  // Next-state and stall/flush decode; a taken branch beats any stall.
  always_comb begin
    w_next_state  = r_state;
    w_next_lu_cnt = r_lu_cnt;
    w_stall       = 1'b0;
    w_flush       = 1'b0;
    if (ex_branch_taken) begin
      w_flush       = 1'b1;
      w_next_state  = IDLE;
      w_next_lu_cnt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_next_lu_cnt = LU_CNT_W'(LOAD_LAT - 1);
              w_next_state  = LU_STALL;
            end
          end
        end
        LU_STALL: begin
          w_stall = 1'b1;
          if (r_lu_cnt <= LU_CNT_W'(1)) begin
            w_next_lu_cnt = '0;
            w_next_state  = IDLE;
          end else begin
            w_next_lu_cnt = r_lu_cnt - LU_CNT_W'(1);
          end
        end
        default: begin
          w_next_state  = IDLE;
          w_next_lu_cnt = '0;
        end
      endcase
    end
  end

  // FSM state and EX-stage source copies; bubbles and flushes load a NOP.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_lu_cnt      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rs1_used <= 1'b0;
      r_ex_rs2_used <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_lu_cnt <= w_next_lu_cnt;
      if (w_stall || ex_branch_taken) begin
        r_ex_rs1      <= '0;
        r_ex_rs2      <= '0;
        r_ex_rs1_used <= 1'b0;
        r_ex_rs2_used <= 1'b0;
      end else begin
        r_ex_rs1      <= id_rs1_addr;
        r_ex_rs2      <= id_rs2_addr;
        r_ex_rs1_used <= id_rs1_used;
        r_ex_rs2_used <= id_rs2_used;
      end
    end
  end

  fwd_select_lane #(
    .REG_AW         (REG_AW),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SELW           (SELW)
  ) u_lane_a (
    .i_src_addr     (r_ex_rs1),
    .i_src_used     (r_ex_rs1_used),
    .i_fwd_rd_addr  (fwd_rd_addr),
    .i_fwd_regwrite (fwd_regwrite),
    .o_sel          (w_sel_a)
  );

  fwd_select_lane #(
    .REG_AW         (REG_AW),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .SELW           (SELW)
  ) u_lane_b (
    .i_src_addr     (r_ex_rs2),
    .i_src_used     (r_ex_rs2_used),
    .i_fwd_rd_addr  (fwd_rd_addr),
    .i_fwd_regwrite (fwd_regwrite),
    .o_sel          (w_sel_b)
  );

  // Everything is forced quiet while reset is held.
  assign fwd_sel_a = RST_N ? w_sel_a : '0;
  assign fwd_sel_b = RST_N ? w_sel_b : '0;
  assign stall_pc  = RST_N && w_stall;
  assign stall_id  = RST_N && w_stall;
  assign bubble_ex = RST_N && w_stall;
  assign flush_id  = RST_N && w_flush;
  assign flush_ex  = RST_N && w_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt, r_perf_flush_cnt;

  // Free-running wrap-around event counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'(stall_pc);
      r_perf_flush_cnt <= r_perf_flush_cnt + 32'(flush_ex);
    end
  end

  assign perf_stall_cnt = RST_N ? r_perf_stall_cnt : '0;
  assign perf_flush_cnt = RST_N ? r_perf_flush_cnt : '0;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: a driver issues directed and random
// cycles and queues the reference-model response; a monitor pops and compares.
module tb_hazard_forward_unit;

  localparam int unsigned AW   = 5;
  localparam int unsigned NFWD = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SW   = 2;

  typedef struct packed {
    logic               rst_n;
    logic [AW-1:0]      rs1, rs2;
    logic               u1, u2;
    logic [AW-1:0]      exrd;
    logic               exrw, exmr, br;
    logic [NFWD*AW-1:0] frd;
    logic [NFWD-1:0]    frw;
  } in_t;

  typedef struct packed {
    logic [SW-1:0] a, b;
    logic [4:0]    ctl;   // {stall_pc, stall_id, bubble_ex, flush_id, flush_ex}
    logic [31:0]   ps, pf;
  } exp_t;

  logic               CLK = 1'b0;
  logic               RST_N;
  logic [AW-1:0]      id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic               id_rs1_used, id_rs2_used, ex_regwrite, ex_memread, ex_branch_taken;
  logic [NFWD*AW-1:0] fwd_rd_addr;
  logic [NFWD-1:0]    fwd_regwrite;
  logic [SW-1:0]      fwd_sel_a, fwd_sel_b;
  logic               stall_pc, stall_id, bubble_ex, flush_id, flush_ex;
  logic [31:0]        perf_stall_cnt, perf_flush_cnt;

  hazard_forward_unit #(
    .REG_AW         (AW),
    .NUM_FWD_STAGES (NFWD),
    .LOAD_LAT       (LAT)
  ) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rd_addr      (ex_rd_addr),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .fwd_rd_addr     (fwd_rd_addr),
    .fwd_regwrite    (fwd_regwrite),
    .fwd_sel_a       (fwd_sel_a),
    .fwd_sel_b       (fwd_sel_b),
    .stall_pc        (stall_pc),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
  );

  always #5 CLK = ~CLK;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: remaining stall cycles, what sits in EX, event totals.
  int          m_left = 0;
  logic [AW-1:0] m_rs1 = '0, m_rs2 = '0;
  logic        m_u1 = 1'b0, m_u2 = 1'b0;
  int unsigned m_ps = 0, m_pf = 0;

  function automatic logic [SW-1:0] fwd_ref(input logic used, input logic [AW-1:0] a,
                                            input logic [NFWD*AW-1:0] frd,
                                            input logic [NFWD-1:0] frw);
    if (!used || a == '0) return '0;
    for (int k = 0; k < NFWD; k++)
      if (frw[k] && frd[k*AW +: AW] == a) return SW'(k + 1);
    return '0;
  endfunction

  function automatic in_t blank();
    in_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.rst_n = ($urandom_range(0, 49) != 0);
    s.rs1   = AW'($urandom_range(0, 7));
    s.rs2   = AW'($urandom_range(0, 7));
    s.u1    = 1'($urandom_range(0, 1));
    s.u2    = 1'($urandom_range(0, 1));
    s.exrd  = AW'($urandom_range(0, 7));
    s.exrw  = ($urandom_range(0, 3) != 0);
    s.exmr  = ($urandom_range(0, 2) == 0);
    s.br    = ($urandom_range(0, 9) == 0);
    for (int k = 0; k < NFWD; k++) s.frd[k*AW +: AW] = AW'($urandom_range(0, 7));
    s.frw   = NFWD'($urandom);
    return s;
  endfunction

  // Drive one cycle, queue its expected outputs, then advance the model past the edge.
  task automatic step(input in_t s);
    exp_t e;
    logic hz, st, fl;
    @(posedge CLK);
    #1;
    RST_N = s.rst_n;  id_rs1_addr = s.rs1;  id_rs2_addr = s.rs2;
    id_rs1_used = s.u1;  id_rs2_used = s.u2;  ex_rd_addr = s.exrd;
    ex_regwrite = s.exrw;  ex_memread = s.exmr;  ex_branch_taken = s.br;
    fwd_rd_addr = s.frd;  fwd_regwrite = s.frw;

    hz = s.exmr && s.exrw && (s.exrd != '0) &&
         ((s.u1 && s.rs1 == s.exrd) || (s.u2 && s.rs2 == s.exrd));
    fl = s.br;
    st = !s.br && (m_left > 0 || hz);
    e  = '0;
    if (s.rst_n) begin
      e.a   = fwd_ref(m_u1, m_rs1, s.frd, s.frw);
      e.b   = fwd_ref(m_u2, m_rs2, s.frd, s.frw);
      e.ctl = {st, st, st, fl, fl};
`ifdef HAZARD_PERF_CNT_EN
      e.ps  = m_ps;
      e.pf  = m_pf;
`endif
    end
    q.push_back(e);

    if (!s.rst_n) begin
      m_left = 0; m_ps = 0; m_pf = 0;
      m_rs1 = '0; m_rs2 = '0; m_u1 = 1'b0; m_u2 = 1'b0;
    end else begin
      m_ps += st ? 1 : 0;
      m_pf += fl ? 1 : 0;
      if (s.br)            m_left = 0;
      else if (m_left > 0) m_left--;
      else if (hz)         m_left = LAT - 1;
      if (st || s.br) begin
        m_rs1 = '0; m_rs2 = '0; m_u1 = 1'b0; m_u2 = 1'b0;
      end else begin
        m_rs1 = s.rs1; m_rs2 = s.rs2; m_u1 = s.u1; m_u2 = s.u2;
      end
    end
  endtask

  // Monitor: one response per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (fwd_sel_a !== e.a) begin
          n_fail++; $display("FAIL fwd_sel_a t=%0t got %0d exp %0d", $time, fwd_sel_a, e.a);
        end
        n_tests++;
        if (fwd_sel_b !== e.b) begin
          n_fail++; $display("FAIL fwd_sel_b t=%0t got %0d exp %0d", $time, fwd_sel_b, e.b);
        end
        n_tests++;
        if ({stall_pc, stall_id, bubble_ex, flush_id, flush_ex} !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl{spc,sid,bub,fid,fex} t=%0t got %b exp %b", $time,
                   {stall_pc, stall_id, bubble_ex, flush_id, flush_ex}, e.ctl);
        end
        n_tests++;
        if (perf_stall_cnt !== e.ps || perf_flush_cnt !== e.pf) begin
          n_fail++;
          $display("FAIL perf t=%0t got %0d/%0d exp %0d/%0d", $time,
                   perf_stall_cnt, perf_flush_cnt, e.ps, e.pf);
        end
      end
    end
  end

  initial begin
    in_t s, ld;
    RST_N = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; ex_rd_addr = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; fwd_rd_addr = '0; fwd_regwrite = '0;

    s = blank(); s.rst_n = 1'b0;
    step(s); step(s);

    // x5 written by stage 0 and stage 1: youngest wins.
    s = blank(); s.rs1 = 5; s.u1 = 1'b1;
    s.frd[0 +: AW] = 5; s.frd[AW +: AW] = 5; s.frw = 3'b011;
    step(s); step(s);
    // rs2=x7 only in stage 1.
    s = blank(); s.rs2 = 7; s.u2 = 1'b1;
    s.frd[0 +: AW] = 3; s.frd[AW +: AW] = 7; s.frw = 3'b011;
    step(s); step(s);
    // x0 never forwarded.
    s = blank(); s.rs1 = 0; s.u1 = 1'b1; s.frd[0 +: AW] = 0; s.frw = 3'b001;
    step(s); step(s);

    // lw x3 in EX, add x4,x3,x1 in ID: two stall cycles, then release.
    ld = blank(); ld.exrd = 3; ld.exrw = 1'b1; ld.exmr = 1'b1;
    ld.rs1 = 3; ld.rs2 = 1; ld.u1 = 1'b1; ld.u2 = 1'b1;
    step(ld); step(ld); step(blank()); step(blank());
    // Taken branch during the second stall cycle.
    step(ld); s = ld; s.br = 1'b1; step(s); step(blank()); step(blank());
    // Reset mid-stall.
    step(ld); s = ld; s.rst_n = 1'b0; step(s); step(blank()); step(blank());

    for (int i = 0; i < 3000; i++) step(rand_in());

    @(posedge CLK);
    @(negedge CLK);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
